chirp_window_gen: RTL and testbench

//  Consumes single-cycle chirp-start pulses from the upstream rising-edge detector on the radar trigger line.

---
 rtl/chirp_window_gen_if.sv | 45 ++++
 rtl/chirp_window_gen.sv | 140 ++++++++++++++
 tb/tb_chirp_window_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/chirp_window_gen_if.sv
// Sequencer-side bus of chirp_window_gen: trigger/config inputs and window status outputs.
// Build option CHIRP_OVERRUN_CNT_EN adds the overrun_cnt_o counter output.
interface chirp_window_gen_if #(
  parameter int DLY_W = 16,
  parameter int SMP_W = 12,
  parameter int CHP_W = 8
);
  logic             enable_i;
  logic             chirp_pulse_i;
  logic [DLY_W-1:0] cfg_delay_i;
  logic [SMP_W-1:0] cfg_samples_i;
  logic [CHP_W-1:0] cfg_chirps_i;
  logic             busy_o;
  logic             sample_en_o;
  logic [SMP_W-1:0] sample_idx_o;
  logic [CHP_W-1:0] chirp_idx_o;
  logic             chirp_done_o;
  logic             frame_done_o;
  logic             overrun_o;
`ifdef CHIRP_OVERRUN_CNT_EN
  logic [15:0]      overrun_cnt_o;

  modport master (
    output enable_i, chirp_pulse_i, cfg_delay_i, cfg_samples_i, cfg_chirps_i,
    input  busy_o, sample_en_o, sample_idx_o, chirp_idx_o, chirp_done_o,
           frame_done_o, overrun_o, overrun_cnt_o
  );
  modport slave (
    input  enable_i, chirp_pulse_i, cfg_delay_i, cfg_samples_i, cfg_chirps_i,
    output busy_o, sample_en_o, sample_idx_o, chirp_idx_o, chirp_done_o,
           frame_done_o, overrun_o, overrun_cnt_o
  );
`else
  modport master (
    output enable_i, chirp_pulse_i, cfg_delay_i, cfg_samples_i, cfg_chirps_i,
    input  busy_o, sample_en_o, sample_idx_o, chirp_idx_o, chirp_done_o,
           frame_done_o, overrun_o
  );
  modport slave (
    input  enable_i, chirp_pulse_i, cfg_delay_i, cfg_samples_i, cfg_chirps_i,
    output busy_o, sample_en_o, sample_idx_o, chirp_idx_o, chirp_done_o,
           frame_done_o, overrun_o
  );
`endif
endinterface

// File: rtl/chirp_window_gen.sv
// Chirp sample-window sequencer: settle delay, N ADC strobes per chirp, chirp/frame done flags.
// Build option CHIRP_OVERRUN_CNT_EN adds a saturating 16-bit count of overrun pulses.
module chirp_window_gen #(
  parameter int DLY_W = 16,
  parameter int SMP_W = 12,
  parameter int CHP_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  chirp_window_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DELAY, SAMPLE} state_t;

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [SMP_W-1:0] smp_last;
  logic [CHP_W-1:0] chp_last;
  logic             busy;
  logic             sample_en;
  logic [SMP_W-1:0] sample_idx;
  logic [CHP_W-1:0] chirp_idx;
  logic             chirp_done;
  logic             frame_done;
  logic             overrun;

  // Shadow registers hold count-minus-one so that a zero config behaves as one.
  logic [SMP_W-1:0] cfg_smp_last;
  logic [CHP_W-1:0] cfg_chp_last;
  logic [SMP_W-1:0] idx_nxt;
  logic             cfg_last_chirp;
  logic             last_chirp;

  assign cfg_smp_last   = (bus.cfg_samples_i == '0) ? '0 : bus.cfg_samples_i - SMP_W'(1);
  assign cfg_chp_last   = (bus.cfg_chirps_i  == '0) ? '0 : bus.cfg_chirps_i  - CHP_W'(1);
  assign idx_nxt        = sample_idx + SMP_W'(1);
  assign cfg_last_chirp = (chirp_idx == cfg_chp_last);
  assign last_chirp     = (chirp_idx == chp_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      smp_last   <= '0;
      chp_last   <= '0;
      busy       <= 1'b0;
      sample_en  <= 1'b0;
      sample_idx <= '0;
      chirp_idx  <= '0;
      chirp_done <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      chirp_done <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      if (!bus.enable_i) begin
        state      <= IDLE;
        dly_cnt    <= '0;
        busy       <= 1'b0;
        sample_en  <= 1'b0;
        sample_idx <= '0;
        chirp_idx  <= '0;
      end else begin
        overrun <= bus.chirp_pulse_i && busy;
        case (state)
          IDLE: begin
            if (bus.chirp_pulse_i) begin
              smp_last <= cfg_smp_last;
              chp_last <= cfg_chp_last;
              busy     <= 1'b1;
              if (bus.cfg_delay_i != '0) begin
                state   <= DELAY;
                dly_cnt <= bus.cfg_delay_i;
              end else begin
                // Zero delay: first strobe goes out on the very next cycle.
                state      <= SAMPLE;
                sample_en  <= 1'b1;
                sample_idx <= '0;
                chirp_done <= (cfg_smp_last == '0);
                frame_done <= (cfg_smp_last == '0) && cfg_last_chirp;
              end
            end
          end
          DELAY: begin
            if (dly_cnt == DLY_W'(1)) begin
              state      <= SAMPLE;
              sample_en  <= 1'b1;
              sample_idx <= '0;
              chirp_done <= (smp_last == '0);
              frame_done <= (smp_last == '0) && last_chirp;
            end else begin
              dly_cnt <= dly_cnt - DLY_W'(1);
            end
          end
          SAMPLE: begin
            if (sample_idx == smp_last) begin
              state      <= IDLE;
              busy       <= 1'b0;
              sample_en  <= 1'b0;
              sample_idx <= '0;
              chirp_idx  <= last_chirp ? '0 : chirp_idx + CHP_W'(1);
            end else begin
              sample_idx <= idx_nxt;
              chirp_done <= (idx_nxt == smp_last);
              frame_done <= (idx_nxt == smp_last) && last_chirp;
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            sample_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy_o       = busy;
  assign bus.sample_en_o  = sample_en;
  assign bus.sample_idx_o = sample_idx;
  assign bus.chirp_idx_o  = chirp_idx;
  assign bus.chirp_done_o = chirp_done;
  assign bus.frame_done_o = frame_done;
  assign bus.overrun_o    = overrun;

`ifdef CHIRP_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ovr_cnt <= '0;
    else if (overrun && (ovr_cnt != 16'hFFFF))
      ovr_cnt <= ovr_cnt + 16'd1;
  end

  assign bus.overrun_cnt_o = ovr_cnt;
`endif

endmodule

// File: tb/tb_chirp_window_gen.sv
// Scoreboard bench for chirp_window_gen: driver predicts strobe/overrun events, monitor checks them.
module tb_chirp_window_gen;
  localparam int DLY_W = 16;
  localparam int SMP_W = 12;
  localparam int CHP_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chirp_window_gen_if #(.DLY_W(DLY_W), .SMP_W(SMP_W), .CHP_W(CHP_W)) bus ();

  chirp_window_gen #(.DLY_W(DLY_W), .SMP_W(SMP_W), .CHP_W(CHP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int idx;
    int cidx;
    bit cd;
    bit fd;
  } strobe_t;

  strobe_t sq[$];
  int      ovq[$];
  strobe_t mon_s;
  int      cyc = 0;
  int      n_chk = 0;
  int      n_pass = 0;
  int      cur_start = 0;
  int      cur_end = -1;
  int      chirp_cnt = 0;
  int      ov_model = 0;
  bit      mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Enable low or reset at edge e: no strobes from edge e on, chirp counter restarts.
  function automatic void abort_at(input int e);
    while (sq.size() > 0 && sq[$].cyc >= e) void'(sq.pop_back());
    if (cur_end >= e) cur_end = e - 1;
    chirp_cnt = 0;
  endfunction

  // One cycle of stimulus; e is the clock edge that samples it.
  task automatic drive(input bit r, input bit en, input bit p, input int d, input int n, input int m);
    int e, ne, me, s;
    @(negedge clk);
    rst_n             = !r;
    bus.enable_i      = en;
    bus.chirp_pulse_i = p;
    bus.cfg_delay_i   = DLY_W'(d);
    bus.cfg_samples_i = SMP_W'(n);
    bus.cfg_chirps_i  = CHP_W'(m);
    e = cyc + 1;
    if (r) begin
      abort_at(e);
      ov_model = 0;
    end else if (!en) begin
      abort_at(e);
    end else if (p) begin
      if (e - 1 > cur_end) begin
        ne = (n == 0) ? 1 : n;
        me = (m == 0) ? 1 : m;
        s  = e + d;
        for (int k = 0; k < ne; k++)
          sq.push_back('{s + k, k, chirp_cnt, (k == ne - 1), (k == ne - 1) && (chirp_cnt == me - 1)});
        cur_start = e;
        cur_end   = s + ne - 1;
        chirp_cnt = (chirp_cnt == me - 1) ? 0 : (chirp_cnt + 1) % 256;
      end else begin
        ovq.push_back(e);
        if (ov_model < 65535) ov_model++;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      drive(0, 1, 0, $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 5));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", bus.busy_o, (cyc >= cur_start && cyc <= cur_end));
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        check("strobe_missing", cyc, sq[0].cyc);
        void'(sq.pop_front());
      end
      if (bus.sample_en_o) begin
        if (sq.size() == 0) begin
          check("strobe_unexpected", sq.size(), 1);
        end else begin
          mon_s = sq.pop_front();
          check("strobe_cyc", cyc, mon_s.cyc);
          check("sample_idx", bus.sample_idx_o, mon_s.idx);
          check("chirp_idx", bus.chirp_idx_o, mon_s.cidx);
          check("chirp_done", bus.chirp_done_o, mon_s.cd);
          check("frame_done", bus.frame_done_o, mon_s.fd);
        end
      end else begin
        check("idle_sample_idx", bus.sample_idx_o, 0);
        check("idle_done", {bus.chirp_done_o, bus.frame_done_o}, 0);
      end
      while (ovq.size() > 0 && ovq[0] < cyc) begin
        check("overrun_missing", cyc, ovq[0]);
        void'(ovq.pop_front());
      end
      if (bus.overrun_o) begin
        if (ovq.size() == 0) check("overrun_unexpected", ovq.size(), 1);
        else check("overrun_cyc", cyc, ovq.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_sample_en"}, bus.sample_en_o, 0);
    check({tag, "_sample_idx"}, bus.sample_idx_o, 0);
    check({tag, "_chirp_idx"}, bus.chirp_idx_o, 0);
    check({tag, "_chirp_done"}, bus.chirp_done_o, 0);
    check({tag, "_frame_done"}, bus.frame_done_o, 0);
    check({tag, "_overrun"}, bus.overrun_o, 0);
  endtask

  initial begin
    bus.enable_i      = 1'b0;
    bus.chirp_pulse_i = 1'b0;
    bus.cfg_delay_i   = '0;
    bus.cfg_samples_i = '0;
    bus.cfg_chirps_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    mon_en = 1'b1;
    idle(2);

    // Two chirps of a two-chirp frame, delay 3, four samples each
    drive(0, 1, 1, 3, 4, 2); idle(20);
    drive(0, 1, 1, 3, 4, 2); idle(20);

    // Zero delay, single sample
    drive(0, 1, 1, 0, 1, 1); idle(4);

    // Pulse during the window: overrun, window undisturbed
    drive(0, 1, 1, 2, 8, 3); idle(2);
    drive(0, 1, 1, 2, 8, 3); idle(12);

    // Pulse coincident with chirp_done is an overrun; the next cycle is accepted
    drive(0, 1, 1, 1, 2, 3); idle(2);
    drive(0, 1, 1, 1, 2, 3);
    drive(0, 1, 1, 1, 2, 3); idle(6);

    // Enable dropped during strobe idx 2
    drive(0, 1, 1, 0, 6, 2); idle(2);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("en_drop_busy", bus.busy_o, 0);
    check("en_drop_chirp_idx", bus.chirp_idx_o, 0);
    idle(4);

    // Reset mid-delay, then a clean restart
    drive(0, 1, 1, 10, 3, 1); idle(3);
    drive(1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    drive(0, 1, 1, 2, 3, 1); idle(10);

    // Randomized traffic with occasional enable drops and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0)
        drive(1, 1, 0, 0, 0, 0);
      else if ($urandom_range(0, 49) == 0)
        drive(0, 0, $urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 3));
      else
        drive(0, 1, ($urandom_range(0, 5) == 0), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 3));
    end
    idle(40);

    check("strobes_left", sq.size(), 0);
    check("overruns_left", ovq.size(), 0);
`ifdef CHIRP_OVERRUN_CNT_EN
    check("overrun_cnt", bus.overrun_cnt_o, ov_model);
`endif
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
